// File: rtl/argon_pkg.sv
// Shared definitions for the memory arbiter: access mask encodings, FSM states,
// requester identifiers and the latched request record.
package argon_pkg;

  // Write mask: how many bytes are stored.
  typedef enum logic [1:0] {
    WR_NONE = 2'b00,
    WR_BYTE = 2'b01,
    WR_HALF = 2'b10,
    WR_WORD = 2'b11
  } wr_mask_e;

  // Read mask: bit 2 selects the sign-extending variant of the width in bits 1:0.
  typedef enum logic [2:0] {
    RD_NONE  = 3'b000,
    RD_BYTE  = 3'b001,
    RD_HALF  = 3'b010,
    RD_WORD  = 3'b011,
    RD_SBYTE = 3'b101,
    RD_SHALF = 3'b110,
    RD_SWORD = 3'b111
  } rd_mask_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ISSUE = 2'b01,
    ST_RESP  = 2'b10
  } arb_state_e;

  typedef enum logic {
    REQ_FETCH = 1'b0,
    REQ_DATA  = 1'b1
  } req_id_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wr_data;
    logic [1:0]  wr_mask;
    logic [2:0]  rd_mask;
  } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and memory-side signals of mem_arbiter bundled as one port.
// slave = arbiter view, master = requesters plus memory (the environment).
interface mem_arbiter_if;

  // Requester 0 (fetch)
  logic        i_p0_req;
  logic [31:0] i_p0_addr;
  logic [31:0] i_p0_wr_data;
  logic [1:0]  i_p0_wr_mask;
  logic [2:0]  i_p0_rd_mask;
  logic        o_p0_gnt;
  logic        o_p0_done;
  logic [31:0] o_p0_rd_data;
  logic [1:0]  o_p0_err;

  // Requester 1 (data)
  logic        i_p1_req;
  logic [31:0] i_p1_addr;
  logic [31:0] i_p1_wr_data;
  logic [1:0]  i_p1_wr_mask;
  logic [2:0]  i_p1_rd_mask;
  logic        o_p1_gnt;
  logic        o_p1_done;
  logic [31:0] o_p1_rd_data;
  logic [1:0]  o_p1_err;

  // Memory side
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wr_data;
  logic [1:0]  o_mem_wr_mask;
  logic [2:0]  o_mem_rd_mask;
  logic [31:0] i_mem_rd_data;
  logic        i_mem_err_address_misaligned;
  logic        i_mem_err_invalid_read_mask;

  modport slave (
    input  i_p0_req, i_p0_addr, i_p0_wr_data, i_p0_wr_mask, i_p0_rd_mask,
    output o_p0_gnt, o_p0_done, o_p0_rd_data, o_p0_err,
    input  i_p1_req, i_p1_addr, i_p1_wr_data, i_p1_wr_mask, i_p1_rd_mask,
    output o_p1_gnt, o_p1_done, o_p1_rd_data, o_p1_err,
    output o_mem_addr, o_mem_wr_data, o_mem_wr_mask, o_mem_rd_mask,
    input  i_mem_rd_data, i_mem_err_address_misaligned, i_mem_err_invalid_read_mask
  );

  modport master (
    output i_p0_req, i_p0_addr, i_p0_wr_data, i_p0_wr_mask, i_p0_rd_mask,
    input  o_p0_gnt, o_p0_done, o_p0_rd_data, o_p0_err,
    output i_p1_req, i_p1_addr, i_p1_wr_data, i_p1_wr_mask, i_p1_rd_mask,
    input  o_p1_gnt, o_p1_done, o_p1_rd_data, o_p1_err,
    input  o_mem_addr, o_mem_wr_data, o_mem_wr_mask, o_mem_rd_mask,
    output i_mem_rd_data, i_mem_err_address_misaligned, i_mem_err_invalid_read_mask
  );

endinterface

// File: rtl/mem_rr_picker.sv
// Two-way round-robin picker: one-hot grant from the request vector, with the
// priority pointer advancing only when the arbiter actually accepts the grant.
module mem_rr_picker
  import argon_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [1:0] i_req,
  input  logic       i_accept,
  output logic [1:0] o_gnt
);

  // Identity of the most recent winner; reset to DATA so FETCH wins first contention.
  req_id_e last_q;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      last_q <= REQ_DATA;
    end else if (i_accept) begin
      last_q <= o_gnt[1] ? REQ_DATA : REQ_FETCH;
    end
  end

  always_comb begin
    o_gnt = 2'b00;
    unique case (i_req)
      2'b01:   o_gnt = 2'b01;
      2'b10:   o_gnt = 2'b10;
      2'b11:   o_gnt = (last_q == REQ_DATA) ? 2'b01 : 2'b10;
      default: o_gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch and a data requester onto one memory port: grant in IDLE,
// drive the access in ISSUE, return data/errors with done in RESP.
module mem_arbiter
  import argon_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_halt,
  mem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  mem_req_t   req0, req1, req_q;
  req_id_e    owner_q;
  logic [1:0] err_q;
  logic [1:0] req_vec;
  logic [1:0] pick;
  logic       run;
  logic       accept;

  assign req0 = '{addr:    bus.i_p0_addr,
                  wr_data: bus.i_p0_wr_data,
                  wr_mask: bus.i_p0_wr_mask,
                  rd_mask: bus.i_p0_rd_mask};
  assign req1 = '{addr:    bus.i_p1_addr,
                  wr_data: bus.i_p1_wr_data,
                  wr_mask: bus.i_p1_wr_mask,
                  rd_mask: bus.i_p1_rd_mask};

  assign req_vec = {bus.i_p1_req, bus.i_p0_req};
  // Outputs stay quiet while reset is held, even if a request is pending.
  assign run     = !i_halt && !i_reset;
  assign accept  = (state_q == ST_IDLE) && run && (|req_vec);

  mem_rr_picker u_picker (
    .i_clk    (i_clk),
    .i_reset  (i_reset),
    .i_req    (req_vec),
    .i_accept (accept),
    .o_gnt    (pick)
  );

  // ---------------------------------------------------------------------------
  // State register: halt freezes the FSM in place.
  // ---------------------------------------------------------------------------
  // NOTE: flops use non-blocking (<=) so every register samples pre-edge values;
  // blocking assignments here would make results depend on statement order.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else if (!i_halt) begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned; a missing default would infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (|req_vec) state_d = ST_ISSUE;
      ST_ISSUE: state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Request / error capture. Requests are sampled once at grant; later changes
  // on the requester side have no effect on the access in flight.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      req_q   <= '0;
      owner_q <= REQ_FETCH;
      err_q   <= 2'b00;
    end else begin
      if (accept) begin
        owner_q <= pick[1] ? REQ_DATA : REQ_FETCH;
        req_q   <= pick[1] ? req1 : req0;
      end
      if ((state_q == ST_ISSUE) && !i_halt) begin
        err_q <= {bus.i_mem_err_address_misaligned, bus.i_mem_err_invalid_read_mask};
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic: everything defaults to zero, so the memory sees no access
  // outside an un-halted ISSUE cycle and data/err are zero without done.
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.o_p0_gnt      = 1'b0;
    bus.o_p1_gnt      = 1'b0;
    bus.o_p0_done     = 1'b0;
    bus.o_p1_done     = 1'b0;
    bus.o_p0_rd_data  = 32'h0;
    bus.o_p1_rd_data  = 32'h0;
    bus.o_p0_err      = 2'b00;
    bus.o_p1_err      = 2'b00;
    bus.o_mem_addr    = 32'h0;
    bus.o_mem_wr_data = 32'h0;
    bus.o_mem_wr_mask = WR_NONE;
    bus.o_mem_rd_mask = RD_NONE;

    unique case (state_q)
      ST_IDLE: begin
        if (run) begin
          bus.o_p0_gnt = pick[0];
          bus.o_p1_gnt = pick[1];
        end
      end
      ST_ISSUE: begin
        if (run) begin
          bus.o_mem_addr    = req_q.addr;
          bus.o_mem_wr_data = req_q.wr_data;
          bus.o_mem_wr_mask = req_q.wr_mask;
          bus.o_mem_rd_mask = req_q.rd_mask;
        end
      end
      ST_RESP: begin
        if (run) begin
          if (owner_q == REQ_DATA) begin
            bus.o_p1_done    = 1'b1;
            bus.o_p1_rd_data = bus.i_mem_rd_data;
            bus.o_p1_err     = err_q;
          end else begin
            bus.o_p0_done    = 1'b1;
            bus.o_p0_rd_data = bus.i_mem_rd_data;
            bus.o_p0_err     = err_q;
          end
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have ports: i_clk  in  1  sole clock; i_reset  in  1  asynchronous, active-high reset.
REQ-002 SHALL have i_halt  in  1  freezes all state and suppresses grants, accesses and completions.
REQ-003 SHALL have per requester N in {0 = fetch, 1 = data}: i_pN_req  in  1  request held until grant.
REQ-004 SHALL have i_pN_addr  in  32; i_pN_wr_data  in  32; i_pN_wr_mask  in  2; i_pN_rd_mask  in  3.
REQ-005 SHALL have o_pN_gnt  out  1  request accepted this cycle; o_pN_done  out  1  access complete.
REQ-006 SHALL have o_pN_rd_data  out  32  read data, valid with done; o_pN_err  out  2  {misaligned, invalid_rd_mask}, valid with done.
REQ-007 SHALL have memory side: o_mem_addr  out  32; o_mem_wr_data  out  32; o_mem_wr_mask  out  2; o_mem_rd_mask  out  3.
REQ-008 SHALL have i_mem_rd_data  in  32; i_mem_err_address_misaligned  in  1; i_mem_err_invalid_read_mask  in  1.

Function
REQ-009 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; one access per 3 cycles.
REQ-010 SHALL, in IDLE with any req high and not halted, assert exactly one o_pN_gnt combinationally and latch that requester's addr, data and masks.
REQ-011 SHALL arbitrate round-robin: on simultaneous requests, grant the requester not granted last; a lone request always wins.
REQ-012 SHALL drive the latched request onto o_mem_* only in ISSUE; in all other states, wr_mask = 2'b00 and rd_mask = 3'b000 (no access).
REQ-013 SHALL latch both memory error inputs at the end of ISSUE.
REQ-014 SHALL, in RESP, pulse o_pN_done for the granted requester only, steer i_mem_rd_data to its o_pN_rd_data, and present the latched errors on o_pN_err.
REQ-015 SHALL hold o_pN_rd_data and o_pN_err at 0 whenever o_pN_done is 0.
REQ-016 SHALL give latency: gnt at cycle T, memory access at T+1, done at T+2; a write-only access (rd_mask 0) still completes with done.
REQ-017 SHALL treat a request with wr_mask = 0 and rd_mask = 0 as a legal no-op access that completes normally.
REQ-018 SHALL ignore request changes after grant; a req still high in RESP is arbitrated again in the next IDLE.
REQ-019 SHALL, while i_halt is high, hold FSM, latches and priority pointer, and force gnt, done and memory masks to 0; the FSM resumes in the same state on deassertion.

Reset
REQ-020 SHALL, on i_reset, asynchronously enter IDLE and drive all outputs to 0, including memory masks; any in-flight access is aborted without done.
REQ-021 SHALL reset the priority pointer so requester 0 wins the first simultaneous contention.

Structure
REQ-022 SHALL place the wr/rd mask encodings (wr: 00 none, 01 byte, 10 half, 11 word; rd: 000 none, 001 byte, 010 half, 011 word, 1xx signed variants) and the FSM state enum in shared package argon_pkg.
REQ-023 SHALL implement round-robin selection in sub-module mem_rr_picker (2 requests in, one-hot grant out, pointer update on accept).

Verification
REQ-024 SHALL cover: p0 reads 0x100 with rd_mask 011 while memory returns 0xDEADBEEF -> o_p0_gnt at T, o_mem_rd_mask = 011 at T+1 only, o_p0_done with rd_data 0xDEADBEEF at T+2.
REQ-025 SHALL cover: p0 and p1 request together from reset -> p0 granted first, then p1; with both held continuously, grants alternate p0, p1, p0.
REQ-026 SHALL cover: p1 writes 0x12345678 at 0x204 with wr_mask 11 -> o_mem_wr_mask = 11 for exactly one cycle, o_p1_done at T+2 with rd_data 0.
REQ-027 SHALL cover: p1 reads 0x103 with rd_mask 011 while memory flags misaligned -> o_p1_err = 2'b10 with done.
REQ-028 SHALL cover: i_halt raised during ISSUE for 5 cycles -> memory masks 0 and no done throughout; access completes 2 cycles after halt drops.
REQ-029 SHALL cover: i_reset asserted during ISSUE -> masks 0 immediately, no done; the next request is granted to p0 from IDLE.
